// File: rtl/countdown_timer.sv
// countdown_timer
//   mm:ss:cc countdown timer with a minutes/seconds preset, four debounced
//   active-low keys and six active-low seven-segment digit outputs.
//
// Parameters
//   TICK_DIV         clk cycles per 10 ms centisecond tick
//   DEBOUNCE_CYCLES  consecutive low cycles before a key press is accepted
//
// Ports
//   clk              system clock, rising-edge active
//   reset            asynchronous, active-high reset
//   key_start_pause  active-low key: start / pause / resume / acknowledge done
//   key_min_inc      active-low key: preset minutes +1 (IDLE only)
//   key_sec_inc      active-low key: preset seconds +1 (IDLE only)
//   key_clear        active-low key: back to IDLE with everything zeroed
//   hex5..hex0       active-low segments {g,f,e,d,c,b,a} for mm, ss, cc digits
//   led_run          high in RUN
//   led_done         high in DONE
//   fsm_state        current FSM state (IDLE=0, RUN=1, PAUSE=2, DONE=3)
//
// Key handshake: each key yields a one-cycle accept pulse; a pulse is consumed
// by the FSM on the same rising edge it is high, there is no back-pressure.
module countdown_timer #(
    parameter int TICK_DIV        = 500000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_start_pause,
    input  logic       key_min_inc,
    input  logic       key_sec_inc,
    input  logic       key_clear,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic [6:0] hex4,
    output logic [6:0] hex5,
    output logic       led_run,
    output logic       led_done,
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // One spare count above DEBOUNCE_CYCLES so a held key parks past the
    // accept value and never pulses again.
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 2);
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    // ------------------------------------------------------------------
    // Debounce: bit 0 start/pause, 1 min_inc, 2 sec_inc, 3 clear
    // ------------------------------------------------------------------
    logic [3:0]      key_raw;
    logic [3:0]      key_pulse;
    logic [DB_W-1:0] db_cnt [4];

    assign key_raw = {key_clear, key_sec_inc, key_min_inc, key_start_pause};

    for (genvar k = 0; k < 4; k++) begin : g_db
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                db_cnt[k] <= '0;
            end else if (key_raw[k]) begin
                db_cnt[k] <= '0;
            end else if (db_cnt[k] != DB_W'(DEBOUNCE_CYCLES + 1)) begin
                db_cnt[k] <= db_cnt[k] + 1'b1;
            end
        end
        assign key_pulse[k] = (db_cnt[k] == DB_W'(DEBOUNCE_CYCLES));
    end

    logic start_p, min_p, sec_p, clear_p;
    assign start_p = key_pulse[0];
    assign min_p   = key_pulse[1];
    assign sec_p   = key_pulse[2];
    assign clear_p = key_pulse[3];

    // ------------------------------------------------------------------
    // BCD helpers
    // ------------------------------------------------------------------
    // Two-digit increment with 59 -> 00 wrap.
    function automatic logic [7:0] inc59(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (v[7:4] == 4'd5) ? 4'd0 : v[7:4] + 4'd1;
        end else begin
            r[7:4] = v[7:4];
            r[3:0] = v[3:0] + 4'd1;
        end
        return r;
    endfunction

    // One-centisecond decrement of mm:ss:cc; tens of seconds and minutes
    // borrow to 5, every other digit to 9.
    function automatic logic [23:0] dec_cs(input logic [23:0] v);
        logic [23:0] r;
        logic        borrow;
        logic [3:0]  d;
        logic [3:0]  dmax;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d    = v[i*4 +: 4];
            dmax = (i == 3 || i == 5) ? 4'd5 : 4'd9;
            if (borrow) begin
                if (d == 4'd0) begin
                    d = dmax;
                end else begin
                    d      = d - 4'd1;
                    borrow = 1'b0;
                end
            end
            r[i*4 +: 4] = d;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // FSM, preset, count and tick divider
    // ------------------------------------------------------------------
    state_t           state, state_n;
    logic [15:0]      preset, preset_n;   // mm:ss BCD
    logic [23:0]      count, count_n;     // mm:ss:cc BCD
    logic [DIV_W-1:0] div, div_n;
    logic             tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            preset <= '0;
            count  <= '0;
            div    <= '0;
        end else begin
            state  <= state_n;
            preset <= preset_n;
            count  <= count_n;
            div    <= div_n;
        end
    end

    always_comb begin
        state_n  = state;
        preset_n = preset;
        count_n  = count;
        div_n    = '0;
        tick     = 1'b0;

        if (clear_p) begin
            state_n  = IDLE;
            preset_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (min_p) preset_n[15:8] = inc59(preset[15:8]);
                    if (sec_p) preset_n[7:0]  = inc59(preset[7:0]);
                    if (start_p && preset != 16'h0000) state_n = RUN;
                end
                RUN: begin
                    // A start pulse pauses and swallows a coincident tick.
                    if (start_p) begin
                        state_n = PAUSE;
                    end else begin
                        tick  = (div == DIV_W'(TICK_DIV - 1));
                        div_n = tick ? '0 : div + 1'b1;
                        if (tick) begin
                            count_n = dec_cs(count);
                            if (count_n == 24'h000000) state_n = DONE;
                        end
                    end
                end
                PAUSE: begin
                    if (start_p) state_n = RUN;
                end
                DONE: begin
                    count_n = '0;
                    if (start_p) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end

        // The count mirrors the preset throughout IDLE, including the edge
        // that leaves IDLE, so RUN always starts from the shown value.
        if (state_n == IDLE || state == IDLE) count_n = {preset_n, 8'h00};
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign hex5      = seg7(count[23:20]);
    assign hex4      = seg7(count[19:16]);
    assign hex3      = seg7(count[15:12]);
    assign hex2      = seg7(count[11:8]);
    assign hex1      = seg7(count[7:4]);
    assign hex0      = seg7(count[3:0]);
    assign led_run   = (state == RUN);
    assign led_done  = (state == DONE);
    assign fsm_state = state;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with TICK_DIV=4, DEBOUNCE_CYCLES=3.
// Observed word: {led_run, led_done, hex5, hex4, hex3, hex2, hex1, hex0}.
module tb_countdown_timer;

    localparam int W = 44;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] keys;   // bit 0 start, 1 min_inc, 2 sec_inc, 3 clear
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic       led_run, led_done;
    logic [1:0] fsm_state;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    countdown_timer #(.TICK_DIV(4), .DEBOUNCE_CYCLES(3)) dut (
        .clk             (clk),
        .reset           (reset),
        .key_start_pause (keys[0]),
        .key_min_inc     (keys[1]),
        .key_sec_inc     (keys[2]),
        .key_clear       (keys[3]),
        .hex0            (hex0),
        .hex1            (hex1),
        .hex2            (hex2),
        .hex3            (hex3),
        .hex4            (hex4),
        .hex5            (hex5),
        .led_run         (led_run),
        .led_done        (led_done),
        .fsm_state       (fsm_state)
    );

    // clock
    always #5 clk = ~clk;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [W-1:0] model(input int mm, input int ss, input int cc,
                                           input bit run, input bit done);
        return {run, done, seg(mm / 10), seg(mm % 10), seg(ss / 10), seg(ss % 10),
                seg(cc / 10), seg(cc % 10)};
    endfunction

    // scoreboard
    task automatic expect_val(input int mm, input int ss, input int cc,
                              input bit run, input bit done);
        exp_q.push_back(model(mm, ss, cc, run, done));
    endtask

    task automatic check(input string tag);
        logic [W-1:0] obs;
        logic [W-1:0] e;
        obs = {led_run, led_done, hex5, hex4, hex3, hex2, hex1, hex0};
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: observed=%h with no expected value queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $display("FAIL %s: observed=%h expected=%h", tag, obs, e);
                $error("check %s", tag);
            end
        end
    endtask

    // driver: hold a key low for the given cycles (starting at a negedge)
    task automatic press(input int k, input int cycles);
        keys[k] = 1'b0;
        repeat (cycles) @(negedge clk);
        keys[k] = 1'b1;
    endtask

    // shortest accepted press, then step to the negedge after it takes effect
    task automatic tap(input int k);
        press(k, 3);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        keys  = 4'hF;
        #2;
        expect_val(0, 0, 0, 0, 0);
        check("reset_state");
        @(negedge clk);
        reset = 1'b0;

        // held key gives exactly one increment
        press(2, 10);
        @(negedge clk);
        expect_val(0, 1, 0, 0, 0);
        check("sec_hold_once");

        // full run from 00:01:00 down to zero
        tap(0);
        expect_val(0, 1, 0, 1, 0);
        check("start_run");
        repeat (4) @(negedge clk);
        expect_val(0, 0, 99, 1, 0);
        check("first_tick");
        repeat (392) @(negedge clk);
        expect_val(0, 0, 1, 1, 0);
        check("one_cs_left");
        repeat (3) @(negedge clk);
        expect_val(0, 0, 1, 1, 0);
        check("one_cs_hold");
        @(negedge clk);
        expect_val(0, 0, 0, 0, 1);
        check("done");
        tap(0);
        expect_val(0, 1, 0, 0, 0);
        check("done_to_idle");

        // clear, then start with zero preset is ignored
        tap(3);
        expect_val(0, 0, 0, 0, 0);
        check("clear_idle");
        tap(0);
        expect_val(0, 0, 0, 0, 0);
        check("zero_start");
        repeat (6) @(negedge clk);
        expect_val(0, 0, 0, 0, 0);
        check("zero_start_hold");

        // borrow across every digit
        tap(1);
        expect_val(1, 0, 0, 0, 0);
        check("min_inc");
        tap(0);
        expect_val(1, 0, 0, 1, 0);
        check("run_1min");
        repeat (4) @(negedge clk);
        expect_val(0, 59, 99, 1, 0);
        check("borrow_all");

        // divider is at 0 here: the start accept lands on the 4th edge = tick edge
        tap(0);
        expect_val(0, 59, 99, 0, 0);
        check("pause_on_tick");
        tap(1);
        expect_val(0, 59, 99, 0, 0);
        check("min_ignored_pause");
        tap(0);
        expect_val(0, 59, 99, 1, 0);
        check("resume");
        repeat (3) @(negedge clk);
        expect_val(0, 59, 99, 1, 0);
        check("resume_hold3");
        @(negedge clk);
        expect_val(0, 59, 98, 1, 0);
        check("resume_tick");

        // clear and start accepted together in RUN (also coincides with a tick)
        keys[0] = 1'b0;
        keys[3] = 1'b0;
        repeat (3) @(negedge clk);
        keys = 4'hF;
        @(negedge clk);
        expect_val(0, 0, 0, 0, 0);
        check("clear_beats_start");

        // asynchronous reset mid-RUN
        tap(2);
        expect_val(0, 1, 0, 0, 0);
        check("preset_again");
        tap(0);
        expect_val(0, 1, 0, 1, 0);
        check("run_again");
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        expect_val(0, 0, 0, 0, 0);
        check("async_reset");
        @(negedge clk);
        reset = 1'b0;

        // 61 presses: 60 wrap back to 00, one more gives 01
        for (int i = 0; i < 61; i++) tap(2);
        expect_val(0, 1, 0, 0, 0);
        check("sec_wrap61");

        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_expected: observed=%0d queued expected=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
